// File: rtl/secuenciador_posicion.sv
// Position sequencer: walks base..base+len-1 (mod 2^ADDR_W), issuing one SPI
// transfer per position and waiting for its completion before advancing.
module secuenciador_posicion #(
    parameter int ADDR_W  = 10,
    parameter int MAX_LEN = 12,
    parameter int LEN_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] posicion,
    input  logic [LEN_W-1:0]  longitud,
    input  logic              abort,
    input  logic              spi_done,
    output logic              spi_go,
    output logic [ADDR_W-1:0] spi_addr,
    output logic [LEN_W-1:0]  indice,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              abortado
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] base, base_nxt;
    logic [LEN_W-1:0]  len, len_nxt;
    logic [LEN_W-1:0]  idx, idx_nxt;
    logic              len_ok;

    logic              go_nxt, busy_nxt, done_nxt, err_nxt, abortado_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [LEN_W-1:0]  indice_nxt;

    assign len_ok = (longitud != '0) && (longitud <= LEN_W'(MAX_LEN));

    // Outputs are registered from their next-cycle values so every pulse is glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            base     <= '0;
            len      <= '0;
            idx      <= '0;
            spi_go   <= 1'b0;
            spi_addr <= '0;
            indice   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            abortado <= 1'b0;
        end else begin
            state    <= state_nxt;
            base     <= base_nxt;
            len      <= len_nxt;
            idx      <= idx_nxt;
            spi_go   <= go_nxt;
            spi_addr <= addr_nxt;
            indice   <= indice_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            err      <= err_nxt;
            abortado <= abortado_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        base_nxt  = base;
        len_nxt   = len;
        idx_nxt   = idx;
        case (state)
            S_IDLE: begin
                if (start && len_ok) begin
                    state_nxt = S_ISSUE;
                    base_nxt  = posicion;
                    len_nxt   = longitud;
                    idx_nxt   = '0;
                end
            end
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (spi_done) begin
                    if (idx == len - LEN_W'(1)) begin
                        state_nxt = S_FIN;
                    end else begin
                        idx_nxt   = idx + LEN_W'(1);
                        state_nxt = S_ISSUE;
                    end
                end
            end
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        // Cancellation outranks completion and FIN.
        if (abort && state != S_IDLE) begin
            state_nxt = S_IDLE;
            idx_nxt   = '0;
        end
    end

    always_comb begin
        go_nxt       = (state_nxt == S_ISSUE);
        busy_nxt     = (state_nxt != S_IDLE);
        done_nxt     = (state_nxt == S_FIN);
        err_nxt      = (state == S_IDLE) && start && !len_ok;
        abortado_nxt = (state != S_IDLE) && abort;
        addr_nxt     = spi_addr;
        indice_nxt   = indice;
        if (go_nxt) begin
            addr_nxt   = base_nxt + ADDR_W'(idx_nxt);
            indice_nxt = idx_nxt;
        end
    end

endmodule

// File: tb/tb_secuenciador_posicion.sv
// Randomized bench for secuenciador_posicion: each run is predicted as a list of
// (address, index) transfers plus a terminal done/abortado event.
module tb_secuenciador_posicion;

    localparam int ADDR_W = 10;
    localparam int LEN_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] posicion;
    logic [LEN_W-1:0]  longitud;
    logic              abort;
    logic              spi_done;
    logic              spi_go;
    logic [ADDR_W-1:0] spi_addr;
    logic [LEN_W-1:0]  indice;
    logic              busy;
    logic              done;
    logic              err;
    logic              abortado;

    int n_checks = 0;
    int n_errors = 0;

    secuenciador_posicion #(.ADDR_W(ADDR_W), .MAX_LEN(12), .LEN_W(LEN_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .posicion (posicion),
        .longitud (longitud),
        .abort    (abort),
        .spi_done (spi_done),
        .spi_go   (spi_go),
        .spi_addr (spi_addr),
        .indice   (indice),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .abortado (abortado)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".go"}, spi_go, 0);
        chk({tag, ".addr"}, spi_addr, 0);
        chk({tag, ".indice"}, indice, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".err"}, err, 0);
        chk({tag, ".abortado"}, abortado, 0);
    endtask

    // One run. abort_at = k (1-based) raises abort together with the k-th spi_done;
    // abort_at <= 0 means no cancellation. poke issues a start while the run is busy.
    task automatic run(input int base, input int len, input int dmin, input int dmax,
                       input int abort_at, input bit poke);
        int d;
        int exp_addr;
        start    = 1'b1;
        posicion = ADDR_W'(base);
        longitud = LEN_W'(len);
        abort    = 1'($urandom_range(1, 0));   // abort in IDLE must be ignored
        step();
        start    = 1'b0;
        abort    = 1'b0;
        posicion = '0;
        longitud = '0;
        for (int i = 0; i < len; i++) begin
            exp_addr = (base + i) % (1 << ADDR_W);
            chk("go", spi_go, 1);
            chk("addr", spi_addr, exp_addr);
            chk("indice", indice, i);
            chk("busy", busy, 1);
            chk("done_early", done, 0);
            chk("abortado_spurious", abortado, 0);
            d = $urandom_range(dmax, dmin);
            spi_done = 1'($urandom_range(1, 0)); // completion seen in ISSUE is ignored
            step();
            spi_done = 1'b0;
            for (int k = 1; k < d; k++) begin
                chk("wait.go", spi_go, 0);
                chk("wait.addr", spi_addr, exp_addr);
                chk("wait.indice", indice, i);
                if (poke && k == 1) begin
                    start    = 1'b1;
                    posicion = ADDR_W'($urandom);
                    longitud = 4'd1;
                end
                step();
                start = 1'b0;
                chk("wait.err", err, 0);
            end
            chk("wait.go", spi_go, 0);
            chk("wait.busy", busy, 1);
            chk("wait.addr", spi_addr, exp_addr);
            spi_done = 1'b1;
            if (i + 1 == abort_at) abort = 1'b1;
            step();
            spi_done = 1'b0;
            if (abort) begin
                abort = 1'b0;
                chk("abort.abortado", abortado, 1);
                chk("abort.busy", busy, 0);
                chk("abort.go", spi_go, 0);
                chk("abort.done", done, 0);
                step();
                chk("abort.abortado_end", abortado, 0);
                chk("abort.go_after", spi_go, 0);
                chk("abort.done_after", done, 0);
                return;
            end
        end
        chk("fin.done", done, 1);
        chk("fin.busy", busy, 1);
        chk("fin.go", spi_go, 0);
        step();
        chk("idle.done", done, 0);
        chk("idle.busy", busy, 0);
        chk("idle.addr_held", spi_addr, (base + len - 1) % (1 << ADDR_W));
    endtask

    task automatic reject(input int len);
        start    = 1'b1;
        posicion = ADDR_W'($urandom);
        longitud = LEN_W'(len);
        step();
        start = 1'b0;
        chk("rej.err", err, 1);
        chk("rej.busy", busy, 0);
        chk("rej.go", spi_go, 0);
        step();
        chk("rej.err_end", err, 0);
        chk("rej.busy2", busy, 0);
        chk("rej.go2", spi_go, 0);
    endtask

    initial begin
        int len;
        int ab;
        rst_n    = 1'b0;
        start    = 1'b0;
        posicion = '0;
        longitud = '0;
        abort    = 1'b0;
        spi_done = 1'b0;
        repeat (3) step();
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) step();
        chk_all_zero("idle");

        run(100, 12, 3, 3, 0, 1'b0);
        run(1020, 6, 1, 1, 0, 1'b0);
        reject(0);
        reject(13);
        run(300, 5, 2, 4, 0, 1'b1);
        run(5, 4, 1, 3, 2, 1'b0);
        run(7, 1, 1, 2, 0, 1'b0);

        // Asynchronous reset in the middle of WAIT.
        start    = 1'b1;
        posicion = 10'd50;
        longitud = 4'd3;
        step();
        start = 1'b0;
        step();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_all_zero("after_rst");
        run(0, 1, 1, 2, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(5, 0) == 0) begin
                reject(($urandom_range(1, 0) == 0) ? 0 : $urandom_range(15, 13));
            end else begin
                len = $urandom_range(12, 1);
                ab  = ($urandom_range(3, 0) == 0) ? $urandom_range(len, 1) : 0;
                run($urandom_range(1023, 0), len, 1, 4, ab, 1'($urandom_range(1, 0)));
            end
            repeat ($urandom_range(2, 0)) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/secuenciador_posicion.md
Name: secuenciador_posicion

Overview:
- Sequences a run of up to 12 consecutive 10-bit display positions starting at a base position.
- For each position it issues one transfer request to the SPI transmitter and waits for completion before moving on.
- Replaces the parallel "position + 1..12" fan-out with one time-multiplexed address stream, so a single SPI channel and character memory port serve the whole run.
- Sits between the text/position control logic (start, base, length) and the SPI transmitter plus character RAM (address, go, done).

Parameters:
- ADDR_W, 10, width of position/address.
- MAX_LEN, 12, maximum positions per run.
- LEN_W, 4, width of length/index fields (must hold MAX_LEN).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to begin a run; sampled only in IDLE.
- posicion  in  ADDR_W  base position; captured on accepted start.
- longitud  in  LEN_W  number of positions in run; captured on accepted start.
- abort  in  1  cancel the current run.
- spi_done  in  1  one-cycle completion pulse from the SPI transmitter.
- spi_go  out  1  one-cycle request to the SPI transmitter.
- spi_addr  out  ADDR_W  current position (character RAM address plus SPI payload address).
- indice  out  LEN_W  offset of the current position within the run (0..longitud-1).
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when a run completes normally.
- err  out  1  one-cycle pulse when a start is rejected.
- abortado  out  1  one-cycle pulse when a run is cancelled.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE. All outputs 0, including spi_addr and indice. Captured base and length are cleared.
- States: IDLE, ISSUE, WAIT, FIN.
- IDLE, start=1 with 1 <= longitud <= MAX_LEN:
  - Capture base=posicion and len=longitud; set idx=0.
  - Next state ISSUE. busy rises the cycle after start.
- IDLE, start=1 with longitud=0 or longitud>MAX_LEN:
  - err=1 for the next cycle. Stay in IDLE; no spi_go is issued.
- ISSUE (exactly one cycle):
  - spi_go=1, spi_addr=(base+idx) mod 2^ADDR_W, indice=idx.
  - Next state WAIT.
  - spi_done seen in ISSUE is ignored.
- WAIT:
  - spi_go=0. spi_addr and indice are held stable.
  - On spi_done=1: if idx==len-1, go to FIN; otherwise idx<=idx+1 and go to ISSUE.
  - No timeout; waits indefinitely.
- FIN (one cycle): done=1, then IDLE. busy drops the cycle after FIN.
- Latency: start at edge N gives spi_go at cycle N+1.
  - spi_done in cycle M gives the next spi_go at M+1.
  - The last spi_done at M gives done at M+1.
- Wrap-around: address addition is modulo 2^ADDR_W with no carry out. Example: base 1020 with len 6 gives 1020,1021,1022,1023,0,1.
- Abort:
  - In ISSUE, WAIT or FIN: next state IDLE, abortado=1 for one cycle, done is not asserted, idx cleared.
  - abort has priority over spi_done and over FIN's done in the same cycle.
  - abort in IDLE has no effect.
- start while busy: ignored, with no err and no change to captured values.
- start and abort in the same IDLE cycle: start is accepted; abort is ignored.
- spi_addr holds its last value in IDLE after a run; it is cleared only by reset.
- Reset mid-run: immediate return to IDLE with all outputs 0. No done or abortado pulse.
- All outputs are registered.

Test Plan:
- Reset then idle: rst_n low for 3 cycles, release, hold inputs at 0 for 10 cycles -> all outputs remain 0, busy=0.
- Normal run: posicion=100, longitud=12, spi_done returned 3 cycles after each spi_go -> exactly 12 spi_go pulses with spi_addr 100..111 and indice 0..11 in order. done pulses one cycle after the 12th spi_done. busy high from start+1 through the FIN cycle.
- Wrap-around: posicion=1020, longitud=6, spi_done one cycle after each spi_go -> spi_addr sequence 1020,1021,1022,1023,0,1, then done. Also check minimum pacing: 2 cycles per position.
- Rejects: longitud=0, then longitud=13 -> err pulse each time, no spi_go, busy stays 0. Then start while busy on a valid run -> ignored, run unchanged.
- Abort: posicion=5, longitud=4, assert abort in the same cycle as the 2nd spi_done -> abortado=1 next cycle, no 3rd spi_go, no done. A following start with posicion=7, longitud=1 -> single spi_go at addr 7, then done.
- Async reset mid-WAIT: drop rst_n between clock edges during a run -> outputs go to 0 immediately, without waiting for a clock edge. After release, a start with posicion=0, longitud=1 completes normally.
